dmem_port_arbiter: RTL and testbench

- Shares a single backing memory port between the fetch stage's instruction requester (imem) and the memory stage's data requester (dmem).
- Sits between the pipeline's imem/dmem interfaces and the memory model or cache.
- Serializes requests, allowing one outstanding transaction at a time.
- Routes each response back to its owner.
- Dmem has fixed priority, with a starvation guard for imem.

---
 rtl/dmem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one backing memory port between the instruction
// requester (imem) and the data requester (dmem). Only one transaction is in
// flight at a time. Dmem has fixed priority; imem is forced to win after
// STARVE_MAX consecutive dmem grants made while imem was waiting.
module dmem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    output logic        busy
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IMEM,
        OWN_DMEM
    } owner_t;

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic [3:0] starve_cnt, starve_nxt;

    logic imem_req;
    logic dmem_req;
    logic grant_i;
    logic grant_d;

    // Saturating increment so the starvation counter can never wrap.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign imem_req = |imem_rmask;
    assign dmem_req = |(dmem_rmask | dmem_wmask);

    // Arbitration: grants only happen from IDLE and never while reset is held,
    // so the memory port is quiet the moment reset asserts.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && !rst) begin
            if (dmem_req && (!imem_req || starve_cnt < STARVE_LIM)) begin
                grant_d = 1'b1;
            end else if (imem_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // Control state register: FSM state, current owner and starvation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next-state and outputs: issue from IDLE, route the response in WAIT.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        mem_addr   = 32'd0;
        mem_rmask  = 4'd0;
        mem_wmask  = 4'd0;
        mem_wdata  = 32'd0;
        imem_resp  = 1'b0;
        imem_rdata = 32'd0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;
        busy       = 1'b0;

        unique case (state)
            IDLE: begin
                // A stray mem_resp here is deliberately ignored.
                if (!imem_req) begin
                    starve_nxt = 4'd0;
                end
                if (grant_d) begin
                    mem_addr  = dmem_addr & WORD_MASK;
                    mem_rmask = dmem_rmask;
                    mem_wmask = dmem_wmask;
                    mem_wdata = dmem_wdata;
                    owner_nxt = OWN_DMEM;
                    state_nxt = WAIT;
                    if (imem_req) begin
                        starve_nxt = sat_inc(starve_cnt);
                    end
                end else if (grant_i) begin
                    mem_addr   = imem_addr & WORD_MASK;
                    mem_rmask  = imem_rmask;
                    owner_nxt  = OWN_IMEM;
                    state_nxt  = WAIT;
                    starve_nxt = 4'd0;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_resp) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                    if (owner == OWN_IMEM) begin
                        imem_resp  = 1'b1;
                        imem_rdata = mem_rdata;
                    end else if (owner == OWN_DMEM) begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = mem_rdata;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: a small memory model with programmable
// latency, an issue log, and a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_resp;
    logic        busy;

    logic        model_resp = 1'b0;
    logic        stray_resp;
    assign mem_resp = model_resp | stray_resp;

    dmem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        bit          is_i;
        logic [31:0] data;
    } exp_t;

    iss_t issue_q[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   lat     = 1;
    bit   issue_flag = 1'b0;
    int   model_cnt  = 0;
    logic [31:0] model_addr = 32'd0;

    // Memory contents seen by the model: a fixed function of the word address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h6000_0017;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Cycle counter used to time-stamp issues.
    always @(posedge clk) cyc <= cyc + 1;

    // Issue monitor: log every request driven onto the memory port.
    always @(negedge clk) begin
        issue_flag = !rst && ((mem_rmask | mem_wmask) != 4'd0);
        if (issue_flag)
            issue_q.push_back('{mem_addr, mem_rmask, mem_wmask, mem_wdata, cyc});
    end

    // Memory model: respond lat cycles after the issue cycle.
    always begin
        @(posedge clk);
        #1;
        model_resp = 1'b0;
        if (issue_flag) begin
            model_cnt  = lat;
            model_addr = issue_q[issue_q.size()-1].addr;
        end
        if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
                model_resp = 1'b1;
                mem_rdata  = data_of(model_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next response, compare it against the scoreboard head,
    // then return just after the following rising edge.
    task automatic wait_resp(input int maxc);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (imem_resp || dmem_resp) begin
                got = 1'b1;
                if (sb_q.size() == 0) begin
                    check("sb_empty_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_owner", {30'd0, imem_resp, dmem_resp}, e.is_i ? 32'd2 : 32'd1);
                    check("resp_rdata", e.is_i ? imem_rdata : dmem_rdata, e.data);
                    check("other_rdata", e.is_i ? dmem_rdata : imem_rdata, 32'd0);
                end
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] exp_addr[6];
        rst = 1'b1;
        imem_addr = 32'd0; imem_rmask = 4'd0;
        dmem_addr = 32'd0; dmem_rmask = 4'd0; dmem_wmask = 4'd0; dmem_wdata = 32'd0;
        stray_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {21'd0, busy, imem_resp, dmem_resp, mem_rmask, mem_wmask}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", imem_rdata | dmem_rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single imem read, misaligned address, 3-cycle memory latency.
        lat = 3;
        imem_addr = 32'h6000_0006; imem_rmask = 4'hF;
        sb_q.push_back('{1'b1, 32'h0000_0013});
        @(negedge clk);
        check("t1_addr", mem_addr, 32'h6000_0004);
        check("t1_rmask", {28'd0, mem_rmask}, 32'hF);
        check("t1_wmask", {28'd0, mem_wmask}, 32'd0);
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_rmask_once", {28'd0, mem_rmask}, 32'd0);
        wait_resp(10);
        imem_rmask = 4'd0;

        // Simultaneous imem read and dmem store: dmem first, imem next cycle.
        lat = 2;
        imem_addr = 32'h0000_0200; imem_rmask = 4'hF;
        dmem_addr = 32'h0000_0100; dmem_wmask = 4'h3; dmem_wdata = 32'h0000_BEEF;
        sb_q.push_back('{1'b0, data_of(32'h0000_0100)});
        sb_q.push_back('{1'b1, data_of(32'h0000_0200)});
        @(negedge clk);
        check("t2_d_addr", mem_addr, 32'h0000_0100);
        check("t2_d_wmask", {28'd0, mem_wmask}, 32'h3);
        check("t2_d_wdata", mem_wdata, 32'h0000_BEEF);
        check("t2_d_rmask", {28'd0, mem_rmask}, 32'd0);
        wait_resp(10);
        dmem_wmask = 4'd0;
        @(negedge clk);
        check("t2_i_addr", mem_addr, 32'h0000_0200);
        check("t2_i_rmask", {28'd0, mem_rmask}, 32'hF);
        check("t2_i_wmask", {28'd0, mem_wmask}, 32'd0);
        check("t2_i_wdata", mem_wdata, 32'd0);
        wait_resp(10);
        imem_rmask = 4'd0;

        // Stray mem_resp in IDLE with no request pending.
        stray_resp = 1'b1;
        @(negedge clk);
        check("stray_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
        check("stray_rdata", imem_rdata | dmem_rdata, 32'd0);
        check("stray_busy", {31'd0, busy}, 32'd0);
        tick();
        // mem_resp in the issue cycle must not complete the new request.
        lat = 2;
        dmem_addr = 32'h0000_0180; dmem_rmask = 4'hF;
        sb_q.push_back('{1'b0, data_of(32'h0000_0180)});
        @(negedge clk);
        check("issue_resp_ign", {31'd0, dmem_resp}, 32'd0);
        check("issue_resp_rm", {28'd0, mem_rmask}, 32'hF);
        tick();
        stray_resp = 1'b0;
        wait_resp(10);
        dmem_rmask = 4'd0;

        // Starvation guard with both requesters continuously pending.
        lat = 1;
        base = issue_q.size();
        imem_addr = 32'h0000_1000; imem_rmask = 4'hF;
        dmem_addr = 32'h0000_2000; dmem_rmask = 4'hF;
        exp_addr = '{32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h1000};
        for (int i = 0; i < 6; i++)
            sb_q.push_back('{exp_addr[i] == 32'h1000, data_of(exp_addr[i])});
        for (int i = 0; i < 6; i++) wait_resp(10);
        imem_rmask = 4'd0; dmem_rmask = 4'd0;
        check("starve_count", issue_q.size() - base, 32'd6);
        for (int i = 0; i < 6 && base + i < issue_q.size(); i++)
            check($sformatf("starve_grant%0d", i), issue_q[base+i].addr, exp_addr[i]);

        // Reset in WAIT with a dmem load outstanding; late response ignored.
        lat = 4;
        dmem_addr = 32'h0000_0300; dmem_rmask = 4'hF;
        @(negedge clk);
        check("rst_issue", {28'd0, mem_rmask}, 32'hF);
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {27'd0, busy, imem_resp, dmem_resp, mem_rmask}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        dmem_rmask = 4'd0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("late_resp_fwd", {30'd0, imem_resp, dmem_resp}, 32'd0);
        check("late_resp_rdata", dmem_rdata, 32'd0);
        check("late_resp_busy", {31'd0, busy}, 32'd0);
        tick();
        lat = 1;
        dmem_addr = 32'h0000_0304; dmem_rmask = 4'hF;
        sb_q.push_back('{1'b0, data_of(32'h0000_0304)});
        @(negedge clk);
        check("post_rst_addr", mem_addr, 32'h0000_0304);
        wait_resp(10);
        dmem_rmask = 4'd0;

        // Back-to-back dmem loads with 1-cycle memory latency.
        lat = 1;
        tick();
        base = issue_q.size();
        for (int i = 0; i < 3; i++)
            sb_q.push_back('{1'b0, data_of(32'h0000_0400 + 32'(4*i))});
        dmem_addr = 32'h0000_0400; dmem_rmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            wait_resp(10);
            if (i < 2) dmem_addr = 32'h0000_0400 + 32'(4*(i+1));
            else dmem_rmask = 4'd0;
        end
        check("b2b_count", issue_q.size() - base, 32'd3);
        for (int i = 1; i < 3 && base + i < issue_q.size(); i++) begin
            check($sformatf("b2b_space%0d", i), issue_q[base+i].cyc - issue_q[base+i-1].cyc, 32'd2);
            check($sformatf("b2b_addr%0d", i), issue_q[base+i].addr, 32'h0000_0400 + 32'(4*i));
        end
        check("sb_drained", sb_q.size(), 32'd0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
